tohost_monitor: RTL
===================

// Module: tohost_monitor
// PURPOSE
//  Responder for the riscv-tests HTIF "tohost" convention. Snoops the core's data-store port and decodes
//  the test program's pass/fail write. Adds a cycle counter and watchdog, and raises registered
//  done/pass/fail/timeout status so the startup bench can end the run and report the result itself.
//  Sits beside core.memory on the store path in the simulation top level. It is not synthesised into the core.
// PARAMETERS
//  TOHOST_ADDR  32'h0000_1000  byte address of the tohost word; compared on all 32 bits
//  MAX_CYCLES   5000           watchdog limit in counted cycles; must be >= 1
//  CNT_W        32             width of cycle_count and store_count
// PORTS
//  clk           in   1      system clock; all state updates on posedge
//  rst           in   1      synchronous, active-high reset
//  en            in   1      count enable; when low, cycle_count and the watchdog hold
//  wr_valid      in   1      core presents a store this cycle
//  wr_ready      out  1      monitor accepts the store; wr_ready = !rst, combinational
//  wr_addr       in   32     store byte address
//  wr_data       in   32     store data
//  wr_strb       in   4      byte strobes
//  done          out  1      sticky: a terminal state has been reached
//  done_pulse    out  1      high for exactly one cycle on entry to a terminal state
//  pass          out  1      sticky: tohost == 1
//  fail          out  1      sticky: tohost is odd and != 1
//  timeout       out  1      sticky: watchdog expired before a tohost write
//  fail_test     out  31     tohost[31:1] when failing (the riscv-tests TESTNUM), else 0
//  tohost_data   out  32     last decoded tohost value
//  proto_warn    out  1      sticky: tohost write that is partial-strobe, or even and nonzero
//  cycle_count   out  CNT_W  cycles counted in RUN with en=1
//  store_count   out  CNT_W  accepted stores of any address in RUN
// BEHAVIOUR
//  Reset and handshake
//  - rst=1 at a posedge: state<=RUN, every sticky flag, counter and data output <=0, done_pulse<=0.
//  - rst mid-run or after done clears all state the same way; no state carries over.
//  - A store is accepted when wr_valid && wr_ready.
//  - A store is a hit when it is accepted and wr_addr==TOHOST_ADDR.
//  - Every output except wr_ready is registered; decode results are visible the cycle after the hit.
//  FSM states: RUN, PASS, FAIL, TIMEOUT. The last three are terminal and absorbing; only rst leaves them.
//  - RUN, hit with wr_strb==4'hf and wr_data==1: go to PASS; tohost_data<=1.
//  - RUN, hit with wr_strb==4'hf and wr_data[0]==1, wr_data!=1: go to FAIL; fail_test<=wr_data[31:1]; tohost_data<=wr_data.
//  - RUN, hit with wr_data==0: ignored; no flag set.
//  - RUN, hit with even nonzero data or a partial strobe: proto_warn<=1 and stay in RUN (syscall/pointer writes are not serviced).
//  - RUN, en=1, no terminating hit, and cycle_count==MAX_CYCLES-1: go to TIMEOUT.
//  - A terminating hit and watchdog expiry in the same cycle: the hit wins (PASS/FAIL), timeout stays 0.
//  - On entry to any terminal state: done<=1 and done_pulse<=1 for one cycle.
//  - Terminal states keep wr_ready=1 and sink all stores.
//  - In terminal states, later tohost writes are ignored: first result wins, and proto_warn does not change.
//  Counters
//  - cycle_count increments by 1 per cycle in RUN with en=1 and freezes in terminal states.
//  - store_count increments per accepted store in RUN, the terminating one included.
//  - Both saturate at all-ones and never wrap.
//  - cycle_count reaches MAX_CYCLES-1 and then stops.
//  Output encoding: pass, fail and timeout are mutually exclusive (one-hot with RUN);
//  done == pass|fail|timeout.
// TESTING
//  T1  rst 1 cycle; store 1 to 0x1000 with strb f at cycle 20 -> cycle 21: pass=1, done_pulse=1 for 1 cycle,
//      tohost_data=1; cycle 22 onward: done_pulse=0 and cycle_count frozen at 20.
//  T2  store 0x0000_0007 to 0x1000 -> fail=1, fail_test=3, pass=0.
//      A later store of 1 to 0x1000 leaves fail=1 and pass=0.
//  T3  MAX_CYCLES=50, en=1, no tohost write -> timeout=1 after 50 counted cycles, cycle_count=49.
//      Hold en=0 for 10 cycles midway -> timeout arrives 10 cycles later.
//  T4  store 1 to 0x1000 in the exact cycle cycle_count==MAX_CYCLES-1 -> pass=1, timeout=0.
//  T5  store 0x8 to 0x1000 strb f, then 1 with strb 4'h1 -> proto_warn=1, state RUN.
//      A later store of 1 with strb f -> pass=1. Stores to 0x1004 never affect status.
//  T6  reach FAIL, then pulse rst 1 cycle -> all outputs 0, cycle_count restarts from 0, a new pass is accepted.

Source files
------------

// File: rtl/tohost_monitor.sv
// Snoops core stores for the HTIF tohost word and keeps pass/fail/timeout status, the watchdog and the counters.
// All status is registered one cycle after the store; wr_ready is only dropped by rst, so stores are never stalled.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned MAX_CYCLES  = 5000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             done,
  output logic             done_pulse,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_test,
  output logic [31:0]      tohost_data,
  output logic             proto_warn,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count
);

  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t state;
  logic   accepted;
  logic   hit;
  logic   full_strb;
  logic   is_pass;
  logic   is_fail;
  logic   is_warn;
  logic   wdog_exp;

  assign wr_ready  = !rst;
  assign accepted  = wr_valid && wr_ready;
  assign hit       = accepted && (wr_addr == TOHOST_ADDR);
  assign full_strb = (wr_strb == 4'hf);
  assign is_pass   = hit && full_strb && (wr_data == 32'd1);
  assign is_fail   = hit && full_strb && wr_data[0] && (wr_data != 32'd1);
  // Zero writes are silently ignored; anything else that is not a clean result is a protocol warning.
  assign is_warn   = hit && (wr_data != 32'd0) && (!full_strb || !wr_data[0]);
  assign wdog_exp  = en && (cycle_count == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      done        <= 1'b0;
      done_pulse  <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_test   <= '0;
      tohost_data <= '0;
      proto_warn  <= 1'b0;
      cycle_count <= '0;
      store_count <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (state == RUN) begin
        if (accepted && (store_count != CNT_MAX))
          store_count <= store_count + 1'b1;
        // The counter parks at the watchdog limit; the expiry itself is taken below.
        if (en && (cycle_count != WDOG_LAST) && (cycle_count != CNT_MAX))
          cycle_count <= cycle_count + 1'b1;
        if (is_warn)
          proto_warn <= 1'b1;
        if (is_pass) begin
          state       <= PASS;
          pass        <= 1'b1;
          done        <= 1'b1;
          done_pulse  <= 1'b1;
          tohost_data <= 32'd1;
        end else if (is_fail) begin
          state       <= FAIL;
          fail        <= 1'b1;
          done        <= 1'b1;
          done_pulse  <= 1'b1;
          fail_test   <= wr_data[31:1];
          tohost_data <= wr_data;
        end else if (wdog_exp) begin
          state      <= TIMEOUT;
          timeout    <= 1'b1;
          done       <= 1'b1;
          done_pulse <= 1'b1;
        end
      end
    end
  end

endmodule
